traffic_light_phase_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 21 ++
 rtl/tlc_dwell_timer.sv | 28 ++
 rtl/traffic_light_phase_ctrl.sv | 145 ++++++++++++++
 tb/tb_traffic_light_phase_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the two-road phase controller: state encoding and lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAIN_G = 3'd1,
    MAIN_Y = 3'd2,
    RED1   = 3'd3,
    SIDE_G = 3'd4,
    SIDE_Y = 3'd5,
    RED2   = 3'd6,
    FLASH  = 3'd7
  } state_t;

  // Lamp vectors are {red, yellow, green}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tlc_dwell_timer.sv
// Loadable down-counter used to time phase dwell; holds at zero until reloaded.
module tlc_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign value = cnt_reg;
  assign zero  = (cnt_reg == '0);

endmodule

// File: rtl/traffic_light_phase_ctrl.sv
// Main/side intersection controller: timed phases, all-red clearance, pedestrian
// early termination of main green, and a blinking flash mode entered from all-red.
module traffic_light_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 20,
  parameter int MIN_GREEN  = 8,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int FLASH_HALF = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  if (CNT_W < 1 || GREEN_CYC < 1 || MIN_GREEN < 1 || YELLOW_CYC < 1 ||
      ALLRED_CYC < 1 || FLASH_HALF < 1 || MIN_GREEN > GREEN_CYC ||
      GREEN_CYC > 2**CNT_W || YELLOW_CYC > 2**CNT_W ||
      ALLRED_CYC > 2**CNT_W || FLASH_HALF > 2**CNT_W) begin : g_param_err
    $error("traffic_light_phase_ctrl: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_HALF - 1);
  // Counter value at or below which MIN_GREEN cycles of main green have elapsed
  localparam logic [CNT_W-1:0] EARLY_THR = CNT_W'(GREEN_CYC - MIN_GREEN);

  state_t           state_reg, state_next;
  logic             ped_reg, ped_next;
  logic             toggle_reg, toggle_next;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  tlc_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next   = state_reg;
    toggle_next  = toggle_reg;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_reg)
      IDLE:   state_next = MAIN_G;
      MAIN_G: if (tmr_zero || (ped_reg && tmr_value <= EARLY_THR)) state_next = MAIN_Y;
      MAIN_Y: if (tmr_zero) state_next = RED1;
      RED1:   if (tmr_zero) state_next = flash_mode ? FLASH : SIDE_G;
      SIDE_G: if (tmr_zero) state_next = SIDE_Y;
      SIDE_Y: if (tmr_zero) state_next = RED2;
      RED2:   if (tmr_zero) state_next = flash_mode ? FLASH : MAIN_G;
      FLASH: begin
        if (!flash_mode) begin
          state_next = RED2;
        end else if (tmr_zero) begin
          toggle_next  = ~toggle_reg;
          tmr_load     = 1'b1;
          tmr_load_val = FLASH_LD;
        end
      end
      default: state_next = IDLE;
    endcase

    // Every state entry reloads the dwell; the flash toggle restarts lit
    if (state_next != state_reg) begin
      tmr_load    = 1'b1;
      toggle_next = (state_next == FLASH);
      case (state_next)
        MAIN_G, SIDE_G: tmr_load_val = GREEN_LD;
        MAIN_Y, SIDE_Y: tmr_load_val = YELLOW_LD;
        RED1, RED2:     tmr_load_val = ALLRED_LD;
        FLASH:          tmr_load_val = FLASH_LD;
        default:        tmr_load_val = '0;
      endcase
    end
  end

  always_comb begin
    ped_next = ped_reg;
    if (state_next == SIDE_G && state_reg != SIDE_G) begin
      ped_next = 1'b0;
    end else if (ped_req && state_reg != SIDE_G) begin
      ped_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      ped_reg    <= 1'b0;
      toggle_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ped_reg    <= ped_next;
      toggle_reg <= toggle_next;
    end
  end

  always_comb begin
    main_rgy = LAMP_R;
    side_rgy = LAMP_R;
    walk     = 1'b0;
    case (state_reg)
      IDLE: begin
        main_rgy = LAMP_OFF;
        side_rgy = LAMP_OFF;
      end
      MAIN_G: main_rgy = LAMP_G;
      MAIN_Y: main_rgy = LAMP_Y;
      SIDE_G: begin
        side_rgy = LAMP_G;
        walk     = 1'b1;
      end
      SIDE_Y: side_rgy = LAMP_Y;
      FLASH: begin
        main_rgy = {1'b0, toggle_reg, 1'b0};
        side_rgy = {toggle_reg, 2'b00};
      end
      default: ;
    endcase
  end

  assign ped_pending = ped_reg;
  assign phase       = state_reg;

  a_no_conflict: assert property (@(posedge clk) disable iff (!reset)
    !((|main_rgy[1:0]) && (|side_rgy[1:0])));

endmodule

// File: tb/tb_traffic_light_phase_ctrl.sv
// Directed checks of phase dwell, pedestrian early exit, flash mode and reset,
// plus a short-timing instance exercised with random requests.
module tb_traffic_light_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset, ped_req, flash_mode;
  logic [2:0] main_rgy, side_rgy, phase;
  logic       walk, ped_pending;
  logic       reset2, ped2, flash2;
  logic [2:0] main2, side2, phase2;
  logic       walk2, pend2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  traffic_light_phase_ctrl dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .flash_mode(flash_mode),
    .main_rgy(main_rgy), .side_rgy(side_rgy), .walk(walk),
    .ped_pending(ped_pending), .phase(phase)
  );

  traffic_light_phase_ctrl #(
    .GREEN_CYC(3), .MIN_GREEN(1), .YELLOW_CYC(1), .ALLRED_CYC(1)
  ) dut2 (
    .clk(clk), .reset(reset2), .ped_req(ped2), .flash_mode(flash2),
    .main_rgy(main2), .side_rgy(side2), .walk(walk2),
    .ped_pending(pend2), .phase(phase2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Steps through one phase from its first cycle; returns with the next phase sampled
  task automatic run_phase(input bit sel, output logic [2:0] ph, output int len,
                           output int walk_cnt, output int pend_cnt,
                           output logic [2:0] m0, output logic [2:0] s0);
    ph = sel ? phase2 : phase;
    m0 = sel ? main2 : main_rgy;
    s0 = sel ? side2 : side_rgy;
    len = 0; walk_cnt = 0; pend_cnt = 0;
    while ((sel ? phase2 : phase) == ph && len < 1000) begin
      len++;
      walk_cnt += int'(sel ? walk2 : walk);
      pend_cnt += int'(sel ? pend2 : ped_pending);
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ped_req = 1'b1; flash_mode = 1'b0;
    step();
    step();
    checks++;
    if ({main_rgy, side_rgy, walk, ped_pending, phase} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got main=%b side=%b walk=%b pend=%b phase=%0d, expected all 0",
               main_rgy, side_rgy, walk, ped_pending, phase);
    end
    ped_req = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_normal_cycle();
    int exp_ph[6]        = '{1, 2, 3, 4, 5, 6};
    int exp_len[6]       = '{20, 4, 2, 20, 4, 2};
    int exp_walk[6]      = '{0, 0, 0, 20, 0, 0};
    logic [2:0] exp_m[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] exp_s[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] ph, m0, s0;
    int len, wc, pc;
    do_reset();
    checks++;
    if (phase !== 3'd0 || main_rgy !== 3'b000 || side_rgy !== 3'b000) begin
      errors++;
      $display("FAIL normal_idle: got phase=%0d main=%b side=%b, expected 0/000/000", phase, main_rgy, side_rgy);
    end
    step();
    for (int k = 0; k < 12; k++) begin
      run_phase(1'b0, ph, len, wc, pc, m0, s0);
      checks++;
      if (ph !== 3'(exp_ph[k % 6]) || len != exp_len[k % 6] || wc != exp_walk[k % 6] ||
          m0 !== exp_m[k % 6] || s0 !== exp_s[k % 6]) begin
        errors++;
        $display("FAIL normal_phase[%0d]: got ph=%0d len=%0d walk=%0d main=%b side=%b, expected ph=%0d len=%0d walk=%0d main=%b side=%b",
                 k, ph, len, wc, m0, s0, exp_ph[k % 6], exp_len[k % 6], exp_walk[k % 6], exp_m[k % 6], exp_s[k % 6]);
      end
      $display("normal phase %0d len %0d", ph, len);
    end
  endtask

  task automatic test_ped_early();
    logic [2:0] ph, m0, s0;
    int len, wc, pc;
    do_reset();
    step();          // main green cycle 1
    step();
    step();          // cycle 3
    ped_req = 1'b1;
    step();          // cycle 4
    ped_req = 1'b0;
    checks++;
    if (ped_pending !== 1'b1) begin
      errors++;
      $display("FAIL ped_latch: got %b expected 1", ped_pending);
    end
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    checks++;
    if (ph !== 3'd1 || len != 5) begin
      errors++;
      $display("FAIL ped_early_green: got ph=%0d total green=%0d, expected ph=1 green=8", ph, len + 3);
    end
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    checks++;
    if (ph !== 3'd3 || len != 2 || pc != 2) begin
      errors++;
      $display("FAIL ped_pending_red1: got ph=%0d len=%0d pend=%0d, expected 3/2/2", ph, len, pc);
    end
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    checks++;
    if (ph !== 3'd4 || len != 20 || wc != 20 || pc != 0) begin
      errors++;
      $display("FAIL ped_walk: got ph=%0d len=%0d walk=%0d pend=%0d, expected 4/20/20/0", ph, len, wc, pc);
    end
    $display("ped early: walk %0d cycles", wc);
  endtask

  task automatic test_ped_late();
    logic [2:0] ph, m0, s0;
    int len, wc, pc;
    do_reset();
    step();          // main green cycle 1
    for (int i = 0; i < 14; i++) step();
    ped_req = 1'b1;  // cycle 15
    step();
    ped_req = 1'b0;
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    checks++;
    if (ph !== 3'd1 || len != 1 || phase !== 3'd2) begin
      errors++;
      $display("FAIL ped_late: got green=%0d next=%0d, expected green=16 next=2", len + 15, phase);
    end
    $display("ped late: green %0d cycles", len + 15);
  endtask

  task automatic test_flash();
    logic [2:0] ph, m0, s0;
    int len, wc, pc;
    logic tog;
    do_reset();
    step();
    for (int k = 0; k < 3; k++) run_phase(1'b0, ph, len, wc, pc, m0, s0);
    flash_mode = 1'b1;
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    checks++;
    if (ph !== 3'd4 || len != 20) begin
      errors++;
      $display("FAIL flash_side_g: got ph=%0d len=%0d, expected 4/20", ph, len);
    end
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    checks++;
    if (ph !== 3'd6 || len != 2) begin
      errors++;
      $display("FAIL flash_red2_in: got ph=%0d len=%0d, expected 6/2", ph, len);
    end
    for (int i = 0; i < 20; i++) begin
      tog = ((i / 5) % 2) == 0;
      checks++;
      if ({phase, main_rgy, side_rgy, walk} !== {3'd7, 1'b0, tog, 1'b0, tog, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL flash_blink[%0d]: got ph=%0d main=%b side=%b walk=%b, expected ph=7 toggle=%b walk=0",
                 i, phase, main_rgy, side_rgy, walk, tog);
      end
      step();
    end
    flash_mode = 1'b0;
    step();
    run_phase(1'b0, ph, len, wc, pc, m0, s0);
    checks++;
    if (ph !== 3'd6 || len != 2 || phase !== 3'd1) begin
      errors++;
      $display("FAIL flash_exit: got ph=%0d len=%0d next=%0d, expected 6/2/1", ph, len, phase);
    end
    $display("flash exit via red2 len %0d", len);
  endtask

  task automatic test_reset_mid();
    logic [2:0] ph, m0, s0;
    int len, wc, pc;
    do_reset();
    step();
    for (int k = 0; k < 4; k++) run_phase(1'b0, ph, len, wc, pc, m0, s0);
    step();          // side yellow cycle 2
    reset = 1'b0;
    ped_req = 1'b1;
    step();
    checks++;
    if ({main_rgy, side_rgy, walk, ped_pending, phase} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: got main=%b side=%b walk=%b pend=%b phase=%0d, expected all 0",
               main_rgy, side_rgy, walk, ped_pending, phase);
    end
    reset = 1'b1;
    step();
    ped_req = 1'b0;
    checks++;
    if (phase !== 3'd1 || ped_pending !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart: got phase=%0d pend=%b, expected 1/1", phase, ped_pending);
    end
    $display("reset mid side yellow: restarted");
  endtask

  task automatic test_small_params();
    int exp_len[6] = '{3, 1, 1, 3, 1, 1};
    logic [2:0] ph, m0, s0;
    int len, wc, pc;
    ped2 = 1'b0; flash2 = 1'b0;
    reset2 = 1'b0;
    step();
    reset2 = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      run_phase(1'b1, ph, len, wc, pc, m0, s0);
      checks++;
      if (ph !== 3'(k % 6 + 1) || len != exp_len[k % 6]) begin
        errors++;
        $display("FAIL small_dwell[%0d]: got ph=%0d len=%0d, expected ph=%0d len=%0d",
                 k, ph, len, k % 6 + 1, exp_len[k % 6]);
      end
    end
    for (int i = 0; i < 10000; i++) begin
      ped2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) flash2 = ~flash2;
      step();
      checks++;
      if ((|main2[1:0]) && (|side2[1:0])) begin
        errors++;
        $display("FAIL small_conflict[%0d]: got main=%b side=%b, expected one road red", i, main2, side2);
      end
    end
    flash2 = 1'b0;
    ped2 = 1'b0;
    $display("small params random run done");
  endtask

  initial begin
    reset2 = 1'b0; ped2 = 1'b0; flash2 = 1'b0;
    test_reset();
    test_normal_cycle();
    test_ped_early();
    test_ped_late();
    test_flash();
    test_reset_mid();
    test_small_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
